// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared UART receive state encodings and default frame geometry
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the raw serial line plus falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic start_edge
);

  logic meta;
  logic sync_q;
  logic prev_q;

  // Reset to the idle (high) level so a released reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta   <= rx;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign rx_s       = sync_q;
  assign start_edge = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer with single-entry valid/ready output buffer
// Optional even-parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 start_edge;
  rx_state_t            state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

`ifdef UART_RX_PARITY_EN
  logic par_acc;
  logic par_bad;
`endif

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // A commit in the same cycle overrides this clear further down.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          // The start-edge cycle itself counts as tick 0 of the start bit.
          tick    <= TICK_ONE;
          bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
          par_acc <= 1'b0;
          par_bad <= 1'b0;
`endif
          if (start_edge) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (tick == TICK_HALF) begin
            tick <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end

        ST_DATA: begin
          if (tick == TICK_LAST) begin
            tick    <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
`ifdef UART_RX_PARITY_EN
            par_acc <= par_acc ^ rx_s;
            if (bit_cnt == BITS_LAST) begin
              state <= ST_PARITY;
            end
`else
            if (bit_cnt == BITS_LAST) begin
              state <= ST_STOP;
            end
`endif
          end else begin
            tick <= tick + TICK_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick == TICK_LAST) begin
            tick    <= '0;
            par_bad <= par_acc ^ rx_s;
            state   <= ST_STOP;
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
`endif

        ST_STOP: begin
          if (tick == TICK_LAST) begin
            tick  <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!rx_s) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err <= 1'b1;
`endif
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
